// File: rtl/ps2_mouse_tracker.sv
// ps2_mouse_tracker
//   Frames 3-byte PS/2 mouse packets from a byte strobe and tracks a clamped cursor.
//   The header byte must have bit3 set; a rejected header or a stalled packet raises
//   sync_err for one cycle. Deltas saturate on overflow, are scaled by an arithmetic
//   right shift of SHIFT, and are added to the cursor with clamping at the screen edges.
// Ports
//   CLOCK                 rising-edge system clock
//   reset                 asynchronous, active-low
//   rx_data / rx_valid    byte from the PS/2 receiver and its 1-cycle strobe
//   clear                 recentre the cursor to INIT_X/INIT_Y on the next edge
//   mouseX / mouseY       clamped cursor position (0,0 = top left)
//   btn_left/right/middle header bits 0..2 of the last packet
//   dx / dy               signed 9-bit deltas of the last packet, unscaled (dy + = up)
//   pkt_valid             1-cycle pulse when a packet has been applied
//   sync_err              1-cycle pulse on a rejected header or intra-packet timeout
module ps2_mouse_tracker #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int COORD_W  = 11,
    parameter int SHIFT    = 0,
    parameter int TIMEOUT  = 150000,
    parameter int INIT_X   = 320,
    parameter int INIT_Y   = 240
) (
    input  logic               CLOCK,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    input  logic               clear,
    output logic [COORD_W-1:0] mouseX,
    output logic [COORD_W-1:0] mouseY,
    output logic               btn_left,
    output logic               btn_right,
    output logic               btn_middle,
    output logic [8:0]         dx,
    output logic [8:0]         dy,
    output logic               pkt_valid,
    output logic               sync_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int PW    = COORD_W + 2;

    typedef enum logic [1:0] {HDR, BX, BY, APPLY} state_t;

    state_t             state_reg, state_next;
    // Only the header bits that matter are kept: overflow flags, sign bits, buttons.
    logic               ovf_y_reg, ovf_y_next, ovf_x_reg, ovf_x_next;
    logic               sgn_y_reg, sgn_y_next, sgn_x_reg, sgn_x_next;
    logic [2:0]         btn_reg, btn_next;
    logic [7:0]         bx_reg, bx_next, by_reg, by_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               err_pend_reg, err_pend_next;
    logic               sync_err_reg, sync_err_next;
    logic               pkt_valid_reg;
    logic [COORD_W-1:0] mouse_x_reg, mouse_y_reg;
    logic [2:0]         btn_out_reg;
    logic [8:0]         dx_reg, dy_reg;

    logic [8:0]         dx_calc, dy_calc;
    logic signed [8:0]  sdx, sdy;
    logic signed [PW-1:0] nx, ny;
    logic [COORD_W-1:0] nx_cl, ny_cl;

    // Framing FSM and timeout counter
    always_comb begin
        state_next    = state_reg;
        ovf_y_next    = ovf_y_reg;
        ovf_x_next    = ovf_x_reg;
        sgn_y_next    = sgn_y_reg;
        sgn_x_next    = sgn_x_reg;
        btn_next      = btn_reg;
        bx_next       = bx_reg;
        by_next       = by_reg;
        cnt_next      = '0;
        err_pend_next = 1'b0;
        // A header rejected during APPLY reports one cycle late so it never
        // overlaps the pkt_valid pulse of the packet being applied.
        sync_err_next = err_pend_reg;
        case (state_reg)
            HDR, APPLY: begin
                state_next = HDR;
                if (rx_valid) begin
                    if (rx_data[3]) begin
                        ovf_y_next = rx_data[7];
                        ovf_x_next = rx_data[6];
                        sgn_y_next = rx_data[5];
                        sgn_x_next = rx_data[4];
                        btn_next   = rx_data[2:0];
                        state_next = BX;
                    end else if (state_reg == APPLY) begin
                        err_pend_next = 1'b1;
                    end else begin
                        sync_err_next = 1'b1;
                    end
                end
            end
            BX: begin
                if (rx_valid) begin
                    bx_next    = rx_data;
                    state_next = BY;
                end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    state_next    = HDR;
                    sync_err_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            BY: begin
                if (rx_valid) begin
                    by_next    = rx_data;
                    state_next = APPLY;
                end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    state_next    = HDR;
                    sync_err_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = HDR;
        endcase
    end

    // Delta decode, saturation, scaling and clamped position update
    always_comb begin
        dx_calc = {sgn_x_reg, bx_reg};
        dy_calc = {sgn_y_reg, by_reg};
        if (ovf_x_reg) dx_calc = sgn_x_reg ? 9'h100 : 9'h0FF;
        if (ovf_y_reg) dy_calc = sgn_y_reg ? 9'h100 : 9'h0FF;
        sdx = $signed(dx_calc) >>> SHIFT;
        sdy = $signed(dy_calc) >>> SHIFT;
        // Two guard bits keep the sum from wrapping before the clamp.
        nx = $signed({2'b00, mouse_x_reg}) + PW'(sdx);
        ny = $signed({2'b00, mouse_y_reg}) - PW'(sdy);
        if (nx < 0)                 nx_cl = '0;
        else if (nx > SCREEN_W - 1) nx_cl = COORD_W'(SCREEN_W - 1);
        else                        nx_cl = nx[COORD_W-1:0];
        if (ny < 0)                 ny_cl = '0;
        else if (ny > SCREEN_H - 1) ny_cl = COORD_W'(SCREEN_H - 1);
        else                        ny_cl = ny[COORD_W-1:0];
    end

    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset) begin
            state_reg     <= HDR;
            ovf_y_reg     <= 1'b0;
            ovf_x_reg     <= 1'b0;
            sgn_y_reg     <= 1'b0;
            sgn_x_reg     <= 1'b0;
            btn_reg       <= '0;
            bx_reg        <= '0;
            by_reg        <= '0;
            cnt_reg       <= '0;
            err_pend_reg  <= 1'b0;
            sync_err_reg  <= 1'b0;
            pkt_valid_reg <= 1'b0;
            mouse_x_reg   <= COORD_W'(INIT_X);
            mouse_y_reg   <= COORD_W'(INIT_Y);
            btn_out_reg   <= '0;
            dx_reg        <= '0;
            dy_reg        <= '0;
        end else begin
            state_reg     <= state_next;
            ovf_y_reg     <= ovf_y_next;
            ovf_x_reg     <= ovf_x_next;
            sgn_y_reg     <= sgn_y_next;
            sgn_x_reg     <= sgn_x_next;
            btn_reg       <= btn_next;
            bx_reg        <= bx_next;
            by_reg        <= by_next;
            cnt_reg       <= cnt_next;
            err_pend_reg  <= err_pend_next;
            sync_err_reg  <= sync_err_next;
            pkt_valid_reg <= (state_reg == APPLY);
            if (state_reg == APPLY) begin
                mouse_x_reg <= nx_cl;
                mouse_y_reg <= ny_cl;
                btn_out_reg <= btn_reg;
                dx_reg      <= dx_calc;
                dy_reg      <= dy_calc;
            end
            // Recentre overrides a same-cycle packet update of the position only.
            if (clear) begin
                mouse_x_reg <= COORD_W'(INIT_X);
                mouse_y_reg <= COORD_W'(INIT_Y);
            end
        end
    end

    assign mouseX     = mouse_x_reg;
    assign mouseY     = mouse_y_reg;
    assign btn_left   = btn_out_reg[0];
    assign btn_right  = btn_out_reg[1];
    assign btn_middle = btn_out_reg[2];
    assign dx         = dx_reg;
    assign dy         = dy_reg;
    assign pkt_valid  = pkt_valid_reg;
    assign sync_err   = sync_err_reg;

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
module tb_ps2_mouse_tracker;

    localparam int TO = 20;

    logic        CLOCK = 1'b0;
    logic        reset, rx_valid, clear;
    logic [7:0]  rx_data;
    logic [10:0] mx0, my0, mx1, my1;
    logic        bl0, br0, bm0, bl1, br1, bm1;
    logic [8:0]  dx0, dy0, dx1, dy1;
    logic        pv0, se0, pv1, se1;

    always #5 CLOCK = ~CLOCK;

    ps2_mouse_tracker #(.TIMEOUT(TO)) dut (
        .CLOCK(CLOCK), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .clear(clear),
        .mouseX(mx0), .mouseY(my0), .btn_left(bl0), .btn_right(br0), .btn_middle(bm0),
        .dx(dx0), .dy(dy0), .pkt_valid(pv0), .sync_err(se0));

    ps2_mouse_tracker #(.SHIFT(1), .TIMEOUT(TO)) dut_s (
        .CLOCK(CLOCK), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .clear(clear),
        .mouseX(mx1), .mouseY(my1), .btn_left(bl1), .btn_right(br1), .btn_middle(bm1),
        .dx(dx1), .dy(dy1), .pkt_valid(pv1), .sync_err(se1));

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [2:0]  btn;
        logic [8:0]  dx;
        logic [8:0]  dy;
        int          cyc;
    } obs_t;

    obs_t sb0[$], sb1[$], seen0[$], seen1[$];
    int   cyc = 0;
    int   n_checks = 0, n_pass = 0, overlap = 0;
    int   mdl_x0, mdl_y0, mdl_x1, mdl_y1;
    bit   track1 = 1'b0;

    always @(posedge CLOCK) cyc <= cyc + 1;

    // Capture every applied packet from each DUT as it is reported.
    always @(negedge CLOCK) begin
        obs_t t;
        if (pv0) begin
            t.x = mx0; t.y = my0; t.btn = {bm0, br0, bl0}; t.dx = dx0; t.dy = dy0; t.cyc = cyc;
            seen0.push_back(t);
        end
        if (pv1 && track1) begin
            t.x = mx1; t.y = my1; t.btn = {bm1, br1, bl1}; t.dx = dx1; t.dy = dy1; t.cyc = cyc;
            seen1.push_back(t);
        end
        if ((pv0 && se0) || (pv1 && se1)) overlap++;
    end

    // Reference model of one packet for a given sensitivity shift.
    function automatic void model(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                                  input int sh, inout int px, inout int py, output obs_t o);
        int dxi, dyi;
        dxi = b0[4] ? int'(b1) - 256 : int'(b1);
        dyi = b0[5] ? int'(b2) - 256 : int'(b2);
        if (b0[6]) dxi = b0[4] ? -256 : 255;
        if (b0[7]) dyi = b0[5] ? -256 : 255;
        px = px + (dxi >>> sh);
        py = py - (dyi >>> sh);
        if (px < 0) px = 0;
        if (px > 639) px = 639;
        if (py < 0) py = 0;
        if (py > 479) py = 479;
        o.x = px[10:0]; o.y = py[10:0]; o.btn = b0[2:0];
        o.dx = dxi[8:0]; o.dy = dyi[8:0]; o.cyc = 0;
    endfunction

    // Called at a negedge; the byte is sampled on the following rising edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge CLOCK);
        rx_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input bit clr);
        obs_t e;
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        model(b0, b1, b2, 0, mdl_x0, mdl_y0, e);
        if (clr) begin mdl_x0 = 320; mdl_y0 = 240; e.x = 11'd320; e.y = 11'd240; end
        e.cyc = cyc + 1;
        sb0.push_back(e);
        model(b0, b1, b2, 1, mdl_x1, mdl_y1, e);
        if (clr) begin mdl_x1 = 320; mdl_y1 = 240; e.x = 11'd320; e.y = 11'd240; end
        e.cyc = cyc + 1;
        if (track1) sb1.push_back(e);
        if (clr) begin
            clear = 1'b1;
            @(negedge CLOCK);
            clear = 1'b0;
        end
    endtask

    task automatic wait_seen(input bit which, output bit got);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if ((which ? seen1.size() : seen0.size()) > 0) got = 1'b1;
            else begin @(negedge CLOCK); #1; end
        end
        if (!got) got = (which ? seen1.size() : seen0.size()) > 0;
    endtask

    task automatic do_reset();
        @(negedge CLOCK);
        reset = 1'b0;
        repeat (2) @(negedge CLOCK);
        reset = 1'b1;
        mdl_x0 = 320; mdl_y0 = 240; mdl_x1 = 320; mdl_y1 = 240;
    endtask

    task automatic test_reset();
        reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; clear = 1'b0;
        repeat (3) @(negedge CLOCK);
        reset = 1'b1;
        mdl_x0 = 320; mdl_y0 = 240; mdl_x1 = 320; mdl_y1 = 240;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({mx0, my0} !== {11'd320, 11'd240})
                $display("FAIL reset_pos c%0d: got x=%0d y=%0d, want x=320 y=240", i, mx0, my0);
            else n_pass++;
            n_checks++;
            if ({bl0, br0, bm0, dx0, dy0, pv0, se0} !== 23'd0)
                $display("FAIL reset_outs c%0d: got btn=%b%b%b dx=%h dy=%h pv=%b se=%b, want all 0",
                         i, bm0, br0, bl0, dx0, dy0, pv0, se0);
            else n_pass++;
            @(negedge CLOCK);
        end
    endtask

    task automatic test_move();
        obs_t o, e;
        bit got;
        do_reset();
        send_pkt(8'h08, 8'h0A, 8'h05, 1'b0);
        wait_seen(0, got);
        e = sb0.pop_front();
        n_checks++;
        if (!got) $display("FAIL move_pkt: no pkt_valid within 20 cycles");
        else begin
            o = seen0.pop_front();
            if (o !== e) $display("FAIL move_pkt: got x=%0d y=%0d btn=%b dx=%h dy=%h cyc=%0d, want x=%0d y=%0d btn=%b dx=%h dy=%h cyc=%0d",
                                  o.x, o.y, o.btn, o.dx, o.dy, o.cyc, e.x, e.y, e.btn, e.dx, e.dy, e.cyc);
            else n_pass++;
        end
        @(negedge CLOCK); #1;
        n_checks++;
        if (pv0 !== 1'b0) $display("FAIL move_width: got pkt_valid=%b one cycle later, want 0", pv0);
        else n_pass++;
    endtask

    task automatic test_negative();
        obs_t o, e;
        bit got;
        do_reset();
        send_pkt(8'h38, 8'hF6, 8'hFB, 1'b0);
        send_pkt(8'h09, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 2; i++) begin
            wait_seen(0, got);
            e = sb0.pop_front();
            n_checks++;
            if (!got) $display("FAIL neg_pkt%0d: no pkt_valid within 20 cycles", i);
            else begin
                o = seen0.pop_front();
                if (o !== e) $display("FAIL neg_pkt%0d: got x=%0d y=%0d btn=%b dx=%h dy=%h cyc=%0d, want x=%0d y=%0d btn=%b dx=%h dy=%h cyc=%0d",
                                      i, o.x, o.y, o.btn, o.dx, o.dy, o.cyc, e.x, e.y, e.btn, e.dx, e.dy, e.cyc);
                else n_pass++;
            end
        end
    endtask

    // Five packets sent with no idle cycle: the next header lands in APPLY.
    task automatic test_clamp_back_to_back();
        obs_t o, e;
        bit got;
        do_reset();
        for (int i = 0; i < 4; i++) send_pkt(8'h08, 8'h7F, 8'h00, 1'b0);
        send_pkt(8'h48, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            wait_seen(0, got);
            e = sb0.pop_front();
            n_checks++;
            if (!got) $display("FAIL clamp_pkt%0d: no pkt_valid within 20 cycles", i);
            else begin
                o = seen0.pop_front();
                if (o !== e) $display("FAIL clamp_pkt%0d: got x=%0d y=%0d btn=%b dx=%h dy=%h cyc=%0d, want x=%0d y=%0d btn=%b dx=%h dy=%h cyc=%0d",
                                      i, o.x, o.y, o.btn, o.dx, o.dy, o.cyc, e.x, e.y, e.btn, e.dx, e.dy, e.cyc);
                else n_pass++;
            end
        end
    endtask

    task automatic test_sync();
        obs_t o, e;
        bit got;
        int k;
        do_reset();
        send_byte(8'h00);
        n_checks++;
        if (se0 !== 1'b1) $display("FAIL bad_hdr_pulse: got sync_err=%b after rejected header, want 1", se0);
        else n_pass++;
        @(negedge CLOCK);
        n_checks++;
        if (se0 !== 1'b0) $display("FAIL bad_hdr_width: got sync_err=%b a cycle later, want 0", se0);
        else n_pass++;
        send_byte(8'h08);
        send_byte(8'h0A);
        k = 0;
        for (int i = 1; i <= TO + 5 && k == 0; i++) begin
            @(negedge CLOCK);
            if (se0) k = i;
        end
        n_checks++;
        if (k != TO) $display("FAIL timeout_cycle: got sync_err after %0d idle cycles (0 = never), want %0d", k, TO);
        else n_pass++;
        n_checks++;
        if (seen0.size() != 0) $display("FAIL timeout_nopkt: got %0d packets from a partial packet, want 0", seen0.size());
        else n_pass++;
        seen0.delete();
        send_pkt(8'h08, 8'h0A, 8'h05, 1'b0);
        wait_seen(0, got);
        e = sb0.pop_front();
        n_checks++;
        if (!got) $display("FAIL resync_pkt: no pkt_valid within 20 cycles");
        else begin
            o = seen0.pop_front();
            if (o !== e) $display("FAIL resync_pkt: got x=%0d y=%0d btn=%b dx=%h dy=%h cyc=%0d, want x=%0d y=%0d btn=%b dx=%h dy=%h cyc=%0d",
                                  o.x, o.y, o.btn, o.dx, o.dy, o.cyc, e.x, e.y, e.btn, e.dx, e.dy, e.cyc);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midpacket();
        obs_t o, e;
        bit got;
        do_reset();
        send_byte(8'h08);
        send_byte(8'h7F);
        do_reset();
        send_pkt(8'h08, 8'h0A, 8'h05, 1'b0);
        wait_seen(0, got);
        e = sb0.pop_front();
        n_checks++;
        if (!got) $display("FAIL midreset_pkt: no pkt_valid within 20 cycles");
        else begin
            o = seen0.pop_front();
            if (o !== e) $display("FAIL midreset_pkt: got x=%0d y=%0d btn=%b dx=%h dy=%h cyc=%0d, want x=%0d y=%0d btn=%b dx=%h dy=%h cyc=%0d",
                                  o.x, o.y, o.btn, o.dx, o.dy, o.cyc, e.x, e.y, e.btn, e.dx, e.dy, e.cyc);
            else n_pass++;
        end
    endtask

    // Second packet has clear asserted during its APPLY cycle.
    task automatic test_shift_clear();
        obs_t o, e;
        bit got;
        do_reset();
        seen1.delete();
        track1 = 1'b1;
        send_pkt(8'h28, 8'h0B, 8'hFD, 1'b0);
        send_pkt(8'h28, 8'h0B, 8'hFD, 1'b1);
        for (int i = 0; i < 2; i++) begin
            wait_seen(1, got);
            e = sb1.pop_front();
            n_checks++;
            if (!got) $display("FAIL shift_pkt%0d: no pkt_valid within 20 cycles", i);
            else begin
                o = seen1.pop_front();
                if (o !== e) $display("FAIL shift_pkt%0d: got x=%0d y=%0d btn=%b dx=%h dy=%h cyc=%0d, want x=%0d y=%0d btn=%b dx=%h dy=%h cyc=%0d",
                                      i, o.x, o.y, o.btn, o.dx, o.dy, o.cyc, e.x, e.y, e.btn, e.dx, e.dy, e.cyc);
                else n_pass++;
            end
            wait_seen(0, got);
            e = sb0.pop_front();
            n_checks++;
            if (!got) $display("FAIL noshift_pkt%0d: no pkt_valid within 20 cycles", i);
            else begin
                o = seen0.pop_front();
                if (o !== e) $display("FAIL noshift_pkt%0d: got x=%0d y=%0d btn=%b dx=%h dy=%h cyc=%0d, want x=%0d y=%0d btn=%b dx=%h dy=%h cyc=%0d",
                                      i, o.x, o.y, o.btn, o.dx, o.dy, o.cyc, e.x, e.y, e.btn, e.dx, e.dy, e.cyc);
                else n_pass++;
            end
        end
        track1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_move();
        test_negative();
        test_clamp_back_to_back();
        test_sync();
        test_reset_midpacket();
        test_shift_clear();
        repeat (4) @(negedge CLOCK);
        n_checks++;
        if (seen0.size() != 0 || seen1.size() != 0)
            $display("FAIL extra_pkts: got %0d/%0d unexpected pkt_valid pulses, want 0/0", seen0.size(), seen1.size());
        else n_pass++;
        n_checks++;
        if (overlap != 0) $display("FAIL pulse_overlap: got %0d cycles with pkt_valid and sync_err both high, want 0", overlap);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
